serial_tx: RTL

//  Parallel-to-serial frame transmitter: accepts a DATA_W word over a valid/ready handshake.

---
 rtl/serial_pkg.sv | 5 +
 rtl/serial_tx_if.sv | 10 +
 rtl/serial_tx_bit_timer.sv | 16 +
 rtl/serial_tx.sv | 64 ++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the single-wire serial link.
package serial_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: word handshake plus serial line and busy status of the transmitter.
interface serial_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic txd;
  logic busy;
  modport master (output tx_data, tx_valid, input tx_ready, txd, busy);
  modport slave (input tx_data, tx_valid, output tx_ready, txd, busy);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: free-running 0..DIV-1 divider producing a tick on the last cycle of each bit.
module bit_timer #(parameter int DIV = 4) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == LAST;
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: frames a handshaked word as start bit, data LSB first, stop bit(s) on a registered line.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV       = 4,
  parameter int STOP_BITS = 1
) (
  input logic       clk,
  input logic       reset,
  serial_tx_if.slave bus
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  tx_state_t state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic txd_q, txd_d;
  logic tick;
  // Divider held at zero while idle so the start bit gets a full DIV cycles.
  bit_timer #(.DIV(DIV)) u_timer (.clk(clk), .reset(reset), .clr(state_q == IDLE), .tick(tick));
  assign bus.tx_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.txd = txd_q;
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    case (state_q)
      IDLE: if (bus.tx_valid) begin
        state_d = START;
        sh_d = bus.tx_data;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        if (bit_q == LAST_DATA) state_d = STOP;
        else begin
          sh_d = sh_q >> 1;
          bit_d = bit_q + 1'b1;
        end
      end
      STOP: if (tick) begin
        if (bit_q == LAST_STOP) state_d = IDLE;
        else bit_d = bit_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) bit_d = '0;
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : LINE_IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      bit_q <= '0;
      txd_q <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      txd_q <= txd_d;
    end
endmodule
